instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Sits directly upstream of the control unit.
- Holds the program counter and reads 16-bit instructions from instruction memory over a req/ack handshake.
- Latches each instruction into an instruction register and presents it downstream with a valid/ready handshake.
- Detects HALT, and optionally JUMP, to steer the program counter.

Parameters:
- ADDR_W, 8: program counter and memory address width in bits (1..12).
- RESET_PC, 0: program counter value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; starts fetching from IDLE.
- mem_addr  output  ADDR_W  instruction memory address; always equals pc.
- mem_req  output  1  registered read request to instruction memory.
- mem_rdata  input  16  instruction word from memory; valid when mem_ack is high.
- mem_ack  input  1  read complete; sampled only while mem_req is high.
- instruction  output  16  instruction register, feeding the control unit.
- instr_valid  output  1  instruction holds an unconsumed word.
- instr_ready  input  1  downstream accepts the word.
- pc  output  ADDR_W  address of the instruction being fetched or held.
- halted  output  1  sticky flag; HALT has been consumed.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values, applied immediately on reset assertion:
  - pc = RESET_PC
  - mem_req = 0
  - instruction = 16'h0000
  - instr_valid = 0
  - halted = 0
  - state = IDLE
- All outputs are registered.
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE:
  - mem_req = 0.
  - start = 1 at an edge: mem_req <= 1 and state <= FETCH.
- FETCH:
  - mem_req is held high and mem_addr = pc.
  - Edge with mem_ack = 1: instruction <= mem_rdata, instr_valid <= 1, mem_req <= 0, state <= ISSUE.
  - Wait is unbounded; mem_rdata is ignored while mem_ack = 0.
- ISSUE:
  - instruction is held stable while instr_valid = 1 and instr_ready = 0.
  - Handshake edge (instr_valid and instr_ready both 1): instr_valid <= 0, then classify opcode = instruction[15:12].
  - Opcode 4'b1111 (HALT): pc unchanged, halted <= 1, state <= HALTED, no further request.
  - Any other opcode: pc <= pc + 1, wrapping modulo 2^ADDR_W (e.g. ADDR_W=8, pc 8'hFF -> 8'h00).
  - After a non-HALT handshake: mem_req <= 1 and state <= FETCH on the same edge.
- HALTED:
  - Terminal state; only reset leaves it.
  - start, mem_ack and instr_ready are ignored.
- Latency:
  - start edge -> mem_req high next cycle.
  - With mem_ack returned on the first request cycle and instr_ready held high, throughput is one instruction per 2 cycles.
- Boundary conditions:
  - start outside IDLE is ignored.
  - mem_ack while mem_req = 0 is ignored.
  - Reset during FETCH drops mem_req at once and discards the pending read; a late mem_ack after reset release (state IDLE) is ignored.
  - instr_ready while instr_valid = 0 has no effect.
- Width rule: the HALT opcode compare uses the full 4 bits.

Optional Feature:
- Macro: FETCH_JUMP_EN.
- Defined:
  - Opcode 4'b1000 is JUMP: on its handshake edge pc <= instruction[ADDR_W-1:0] (absolute target) instead of pc + 1, then FETCH.
  - A JUMP to its own address loops indefinitely.
- Not defined: opcode 4'b1000 is treated like any other non-HALT opcode (pc + 1).

Test Plan:
- Reset/start: hold reset, then release with RESET_PC = 0 and pulse start -> mem_req = 1, mem_addr = 8'h00 next cycle; all outputs were at reset values before start.
- Straight-line fetch: memory returns 16'h0003, 16'h1004, 16'h6005 with 0-cycle ack and instr_ready = 1 -> instruction shows the three words in order at pc 0, 1, 2, each instr_valid for 1 cycle, 2 cycles per instruction.
- Backpressure and memory wait:
  - mem_ack delayed 3 cycles -> mem_req stays high for 4 cycles.
  - instr_ready low for 5 cycles -> instruction and pc stable, no new mem_req until the handshake.
- HALT: word 16'hF000 at pc 3 consumed -> halted = 1, pc = 3, mem_req stays 0; a later start pulse has no effect.
- Wrap and reset mid-fetch:
  - pc = 8'hFF with a non-HALT word -> next mem_addr = 8'h00.
  - reset asserted during a pending FETCH -> mem_req = 0 immediately; a late mem_ack is ignored.
- FETCH_JUMP_EN: 16'h8020 at pc 5 -> next mem_addr = 8'h20. With the macro undefined, the same word -> next mem_addr = 8'h06.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter, instruction memory read and instruction register
// Optional macro FETCH_JUMP_EN: opcode 4'b1000 loads pc from the instruction's low ADDR_W bits.
module instruction_fetch #(
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ack,
   output logic [15:0]       instruction,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   localparam logic [3:0] OP_HALT = 4'b1111;
   localparam logic [3:0] OP_JUMP = 4'b1000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      ISSUE  = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t            state;
   logic [3:0]        opcode;
   logic              handshake;
   logic [ADDR_W-1:0] pc_next;

   assign opcode    = instruction[15:12];
   assign handshake = instr_valid && instr_ready;
   assign mem_addr  = pc;

   // Next pc for a non-HALT instruction; the +1 wraps modulo 2^ADDR_W.
   always_comb begin
      pc_next = pc + ADDR_W'(1);
`ifdef FETCH_JUMP_EN
      if (opcode == OP_JUMP)
         pc_next = instruction[ADDR_W-1:0];
`else
      if (opcode == OP_JUMP)
         pc_next = pc + ADDR_W'(1);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= ADDR_W'(RESET_PC);
         mem_req     <= 1'b0;
         instruction <= 16'h0000;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mem_req <= 1'b0;
               if (start) begin
                  mem_req <= 1'b1;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               if (mem_req && mem_ack) begin
                  instruction <= mem_rdata;
                  instr_valid <= 1'b1;
                  mem_req     <= 1'b0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (handshake) begin
                  instr_valid <= 1'b0;
                  if (opcode == OP_HALT) begin
                     halted <= 1'b1;
                     state  <= HALTED;
                  end else begin
                     pc      <= pc_next;
                     mem_req <= 1'b1;
                     state   <= FETCH;
                  end
               end
            end
            HALTED: begin
               mem_req <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
